// File: rtl/serial_subtractor_ctrl_if.sv
// Host-side handshake and operand/result bundle for the bit-serial subtractor.
// The host drives start and the operands. The subtractor drives status and results.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin_init;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin_init,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin_init,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor controller. It computes a - b - bin_init, LSB first,
// one bit per clock, through a single full-subtractor cell.
// The outcome is diff = (a - b - bin_init) mod 2^WIDTH, plus the final borrow.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8   // legal range 2..32
) (
    input logic                     clk,
    input logic                     rst,
    serial_subtractor_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] racc;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             cell_diff;
    logic             cell_bout;

    // Full-subtractor cell acting on the current LSBs and the running borrow.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        cell_diff = sa[0] ^ sb[0] ^ brw;
        cell_bout = (~sa[0] & sb[0]) | (~sa[0] & brw) | (sb[0] & brw);
    end

    // Sequencer: capture operands, shift one bit per clock, publish the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            racc   <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            // NOTE: state flops use non-blocking assignments, so every branch reads pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa    <= bus.a;
                        sb    <= bus.b;
                        brw   <= bus.bin_init;
                        cnt   <= '0;
                        racc  <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    brw  <= cell_bout;
                    racc <= {cell_diff, racc[WIDTH-1:1]};
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    if (cnt == LAST_BIT) begin
                        diff_q <= {cell_diff, racc[WIDTH-1:1]};
                        bout_q <= cell_bout;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Status outputs are decoded straight from the state flops.
    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule
